// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester, multiplier and response channels shared by the arbiter and its environment.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_signed;

    logic                mul_start;
    logic [31:0]         mul_op_a;
    logic [31:0]         mul_op_b;
    logic                mul_signed;
    logic                mul_done;
    logic [63:0]         mul_product;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_product;
    logic                rsp_err;
    logic                busy;

    modport slave (
        input  req_valid, req_a, req_b, req_signed,
        input  mul_done, mul_product, rsp_ready,
        output req_ready, mul_start, mul_op_a, mul_op_b, mul_signed,
        output rsp_valid, rsp_id, rsp_product, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_signed,
        output mul_done, mul_product, rsp_ready,
        input  req_ready, mul_start, mul_op_a, mul_op_b, mul_signed,
        input  rsp_valid, rsp_id, rsp_product, rsp_err, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential 32x32 multiplier among N_REQ requesters,
// with a tagged response channel and a watchdog for a multiplier that never answers.
module mult_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_share_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_rsp_id;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic             r_op_signed;
    logic [63:0]      r_rsp_product;
    logic             r_rsp_err;
    logic             r_rsp_valid;
    logic             r_mul_start;
    logic             r_busy;
    logic [CNT_W-1:0] r_wdog;

    logic [N_REQ-1:0] w_rot;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_next_ptr;
    logic [N_REQ-1:0] w_ready;
    logic [31:0]      w_a [N_REQ];
    logic [31:0]      w_b [N_REQ];

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit then wins.
    assign w_rot = (bus.req_valid >> r_rr_ptr) | (bus.req_valid << (N_REQ - int'(r_rr_ptr)));

    always_comb begin
        w_grant_any = 1'b0;
        w_winner    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_grant_any = 1'b1;
                w_winner    = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_next_ptr = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign w_a[gi]     = bus.req_a[32*gi +: 32];
        assign w_b[gi]     = bus.req_b[32*gi +: 32];
        assign w_ready[gi] = !reset && (r_state == IDLE) && w_grant_any
                             && (w_winner == ID_W'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_rsp_id      <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_op_signed   <= 1'b0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_mul_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_wdog        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_op_a      <= w_a[w_winner];
                        r_op_b      <= w_b[w_winner];
                        r_op_signed <= bus.req_signed[w_winner];
                        r_rsp_id    <= w_winner;
                        r_rr_ptr    <= w_next_ptr;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mul_start <= 1'b0;
                    r_wdog      <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    // A completion in the timeout cycle still delivers its product.
                    if (bus.mul_done) begin
                        r_rsp_product <= bus.mul_product;
                        r_rsp_err     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.mul_start   = r_mul_start;
    assign bus.mul_op_a    = r_op_a;
    assign bus.mul_op_b    = r_op_b;
    assign bus.mul_signed  = r_op_signed;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_product = r_rsp_product;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.busy        = r_busy;
endmodule
